// File: rtl/tl_monitor_pkg.sv
// rtl/tl_monitor_pkg.sv - shared types and helpers for the monitor event scheduler
package tl_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } sched_state_e;

    // Index width that stays at least one bit wide for single-entry sets.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_MON_W = idx_w(4);
    localparam int DEF_CHK_W = idx_w(8);
    localparam int DEF_TS_W  = 32;

    typedef struct packed {
        logic [DEF_MON_W-1:0] mon;
        logic [DEF_CHK_W-1:0] chk;
        logic [DEF_TS_W-1:0]  ts;
    } rpt_t;

endpackage

// File: rtl/tl_monitor_event_scheduler_rr_arbiter.sv
// rtl/tl_monitor_event_scheduler_rr_arbiter.sv - round-robin monitor arbiter with grant lock
// Ports: clock/reset_n, clr (sync clear), req (per-monitor request), hold (offer not
// taken this cycle), accept (handshake), gnt_vld/gnt_idx (grant), locked (grant frozen).
module tl_monitor_event_scheduler_rr_arbiter
    import tl_monitor_pkg::*;
#(
    parameter  int NUM_MON = 4,
    localparam int MON_W   = idx_w(NUM_MON)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic [NUM_MON-1:0] req,
    input  logic               hold,
    input  logic               accept,
    output logic               gnt_vld,
    output logic [MON_W-1:0]   gnt_idx,
    output logic               locked
);

    logic [MON_W-1:0] rr_ptr;
    logic [MON_W-1:0] held_idx;
    logic [MON_W-1:0] pick;
    logic             lock_q;
    logic             found;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin : p_search
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = 0; i < NUM_MON; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_MON) j = j - NUM_MON;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = MON_W'(j);
            end
        end
    end

    // An offered but untaken grant stays put until the logger takes it.
    assign gnt_idx = lock_q ? held_idx : pick;
    assign gnt_vld = lock_q | found;
    assign locked  = lock_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            held_idx <= '0;
            lock_q   <= 1'b0;
        end else if (clr) begin
            rr_ptr   <= '0;
            held_idx <= '0;
            lock_q   <= 1'b0;
        end else begin
            lock_q   <= hold;
            held_idx <= gnt_idx;
            if (accept) begin
                rr_ptr <= (gnt_idx == MON_W'(NUM_MON - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_monitor_event_scheduler.sv
// rtl/tl_monitor_event_scheduler.sv - sticky violation collection, report arbitration and fatal halt sequencing
// Ports: clock/reset_n, enable + viol_i (strobes, bit m*NUM_CHK+c), clr_i (sync clear),
// rpt_* (report stream with valid/ready), first_* (first error capture),
// rpt_cnt/drop_cnt (saturating counters), halt_o, state_o (RUN=0, DRAIN=1, HALT=2).
module tl_monitor_event_scheduler
    import tl_monitor_pkg::*;
#(
    parameter  int                 NUM_MON    = 4,
    parameter  int                 NUM_CHK    = 8,
    parameter  int                 TS_W       = 32,
    parameter  int                 CNT_W      = 16,
    parameter  logic [NUM_CHK-1:0] FATAL_MASK = {NUM_CHK{1'b1}},
    parameter  int                 DRAIN_MAX  = 64,
    localparam int                 MON_W      = idx_w(NUM_MON),
    localparam int                 CHK_W      = idx_w(NUM_CHK),
    localparam int                 NBIT       = NUM_MON * NUM_CHK
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NBIT-1:0]   viol_i,
    input  logic              clr_i,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [MON_W-1:0]  rpt_mon,
    output logic [CHK_W-1:0]  rpt_chk,
    output logic [TS_W-1:0]   rpt_ts,
    output logic              first_vld,
    output logic [MON_W-1:0]  first_mon,
    output logic [CHK_W-1:0]  first_chk,
    output logic [TS_W-1:0]   first_ts,
    output logic [CNT_W-1:0]  rpt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              halt_o,
    output logic [1:0]        state_o
);

    localparam int FLAT_W = idx_w(NBIT);
    localparam int DC_W   = idx_w(DRAIN_MAX) + 1;

    sched_state_e state_q, state_d;

    logic [NUM_MON-1:0][NUM_CHK-1:0] pend;
    logic [NBIT-1:0]  pend_flat;
    logic [TS_W-1:0]  ts_store [NBIT];
    logic [TS_W-1:0]  ts_q;
    logic [DC_W-1:0]  drain_cnt;
    logic [CHK_W-1:0] held_chk;

    logic [NUM_MON-1:0] mon_req;
    logic               gnt_vld;
    logic               arb_locked;
    logic [MON_W-1:0]   gnt_mon;
    logic [CHK_W-1:0]   chk_pick;
    logic [CHK_W-1:0]   gnt_chk;
    logic [FLAT_W-1:0]  gnt_flat;
    logic               hs;

    logic [NBIT-1:0]  samp;
    logic [NBIT-1:0]  hs_vec;
    logic [NBIT-1:0]  drop_vec;
    logic [NBIT-1:0]  pend_d;
    logic [NBIT-1:0]  ts_wr;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_nxt;
    logic [MON_W-1:0] f_mon;
    logic [CHK_W-1:0] f_chk;

    assign pend_flat = pend;

    always_comb begin
        for (int m = 0; m < NUM_MON; m++) mon_req[m] = |pend[m];
    end

    tl_monitor_event_scheduler_rr_arbiter #(
        .NUM_MON (NUM_MON)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr_i),
        .req     (mon_req),
        .hold    (rpt_valid & ~rpt_ready),
        .accept  (hs),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_mon),
        .locked  (arb_locked)
    );

    // Lowest pending check within the granted monitor.
    always_comb begin
        chk_pick = '0;
        for (int c = NUM_CHK - 1; c >= 0; c--) begin
            if (pend[gnt_mon][c]) chk_pick = CHK_W'(c);
        end
    end

    // The check index is frozen together with the monitor so a newly raised
    // lower-numbered check cannot alter an offered report.
    assign gnt_chk   = arb_locked ? held_chk : chk_pick;
    assign gnt_flat  = FLAT_W'(gnt_mon * NUM_CHK + gnt_chk);
    assign rpt_valid = gnt_vld && (state_q != ST_HALT);
    assign rpt_mon   = gnt_mon;
    assign rpt_chk   = gnt_chk;
    assign rpt_ts    = ts_store[gnt_flat];
    assign hs        = rpt_valid & rpt_ready;
    assign halt_o    = (state_q == ST_HALT);
    assign state_o   = state_q;

    always_comb begin
        samp     = (state_q == ST_RUN && enable) ? viol_i : '0;
        hs_vec   = hs ? (NBIT'(1) << gnt_flat) : '0;
        // A strobe on a bit being reported this edge re-arms it instead of dropping.
        drop_vec = samp & pend_flat & ~hs_vec;
        pend_d   = (pend_flat & ~hs_vec) | samp;
        ts_wr    = samp & (~pend_flat | hs_vec);
        drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'($countones(drop_vec));
        drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Descending scan so the lowest flat index is the one that remains.
    always_comb begin
        f_mon = '0;
        f_chk = '0;
        for (int m = NUM_MON - 1; m >= 0; m--) begin
            for (int c = NUM_CHK - 1; c >= 0; c--) begin
                if (samp[m * NUM_CHK + c]) begin
                    f_mon = MON_W'(m);
                    f_chk = CHK_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hs && FATAL_MASK[gnt_chk]) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pend_flat == '0 || drain_cnt == DC_W'(DRAIN_MAX - 1)) state_d = ST_HALT;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        if (clr_i) state_d = ST_RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            pend      <= '0;
            rpt_cnt   <= '0;
            drop_cnt  <= '0;
            first_vld <= 1'b0;
            first_mon <= '0;
            first_chk <= '0;
            first_ts  <= '0;
            held_chk  <= '0;
            drain_cnt <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (clr_i) begin
                pend      <= '0;
                rpt_cnt   <= '0;
                drop_cnt  <= '0;
                first_vld <= 1'b0;
                first_mon <= '0;
                first_chk <= '0;
                first_ts  <= '0;
                held_chk  <= '0;
                drain_cnt <= '0;
            end else begin
                pend     <= pend_d;
                drop_cnt <= drop_nxt;
                held_chk <= gnt_chk;
                if (hs && rpt_cnt != '1) rpt_cnt <= rpt_cnt + 1'b1;
                if (!first_vld && (samp != '0)) begin
                    first_vld <= 1'b1;
                    first_mon <= f_mon;
                    first_chk <= f_chk;
                    first_ts  <= ts_q;
                end
                drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            end
        end
    end

    // Timestamps are only meaningful under a pending bit, so no reset is needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NBIT; i++) begin
            if (!clr_i && ts_wr[i]) ts_store[i] <= ts_q;
        end
    end

endmodule

// File: tb/tb_tl_monitor_event_scheduler.sv
// tb/tb_tl_monitor_event_scheduler.sv - directed self-checking bench for tl_monitor_event_scheduler
module tb_tl_monitor_event_scheduler;
    import tl_monitor_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] viol_i;
    logic        clr_i;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_mon;
    logic [2:0]  rpt_chk;
    logic [31:0] rpt_ts;
    logic        first_vld;
    logic [1:0]  first_mon;
    logic [2:0]  first_chk;
    logic [31:0] first_ts;
    logic [15:0] rpt_cnt;
    logic [15:0] drop_cnt;
    logic        halt_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] tsm;
    logic [31:0] t0;

    tl_monitor_event_scheduler #(
        .NUM_MON    (4),
        .NUM_CHK    (8),
        .TS_W       (32),
        .CNT_W      (16),
        .FATAL_MASK (8'h01),
        .DRAIN_MAX  (64)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .viol_i    (viol_i),
        .clr_i     (clr_i),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_mon   (rpt_mon),
        .rpt_chk   (rpt_chk),
        .rpt_ts    (rpt_ts),
        .first_vld (first_vld),
        .first_mon (first_mon),
        .first_chk (first_chk),
        .first_ts  (first_ts),
        .rpt_cnt   (rpt_cnt),
        .drop_cnt  (drop_cnt),
        .halt_o    (halt_o),
        .state_o   (state_o)
    );

    always #5 clock = ~clock;

    // Expected timestamp: free-running count of rising edges out of reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tsm <= '0;
        else          tsm <= tsm + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    function automatic logic [31:0] vbit(input int m, input int c);
        logic [31:0] one;
        one = 32'd1;
        return one << (m * 8 + c);
    endfunction

    task automatic check_rpt(input string tag, input int m, input int c, input logic [31:0] ts);
        check_eq({tag, "_valid"}, rpt_valid, 1);
        check_eq({tag, "_mon"}, rpt_mon, m);
        check_eq({tag, "_chk"}, rpt_chk, c);
        check_eq({tag, "_ts"}, rpt_ts, ts);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; viol_i = '0; clr_i = 1'b0; rpt_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check_eq("rst_valid", rpt_valid, 0);
        check_eq("rst_state", state_o, ST_RUN);
        check_eq("rst_halt", halt_o, 0);
        check_eq("rst_rpt_cnt", rpt_cnt, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        check_eq("rst_first_vld", first_vld, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Strobes are ignored while enable is low.
        viol_i = vbit(0, 5);
        tick();
        viol_i = '0;
        check_eq("en_off_valid", rpt_valid, 0);

        // Single strobe at ts=10.
        enable = 1'b1;
        rpt_ready = 1'b1;
        for (int i = 0; i < 100 && tsm != 32'd10; i++) tick();
        check_eq("t1_align", tsm, 10);
        viol_i = vbit(1, 3);
        tick();
        viol_i = '0;
        check_rpt("t1", 1, 3, 10);
        check_eq("t1_first_vld", first_vld, 1);
        check_eq("t1_first_mon", first_mon, 1);
        check_eq("t1_first_chk", first_chk, 3);
        check_eq("t1_first_ts", first_ts, 10);
        tick();
        check_eq("t1_rpt_cnt", rpt_cnt, 1);
        check_eq("t1_valid_after", rpt_valid, 0);
        check_eq("t1_state", state_o, ST_RUN);

        // Three monitors at once, round robin from 0.
        do_clr();
        check_eq("clr_rpt_cnt", rpt_cnt, 0);
        check_eq("clr_first_vld", first_vld, 0);
        rpt_ready = 1'b0;
        t0 = tsm;
        viol_i = vbit(0, 2) | vbit(2, 5) | vbit(3, 0);
        tick();
        viol_i = '0;
        check_rpt("t2a", 0, 2, t0);
        rpt_ready = 1'b1;
        tick();
        check_rpt("t2b", 2, 5, t0);
        tick();
        check_rpt("t2c", 3, 0, t0);
        tick();
        check_eq("t2_rpt_cnt", rpt_cnt, 3);
        check_eq("t2_state_drain", state_o, ST_DRAIN);
        check_eq("t2_valid_drain", rpt_valid, 0);
        tick();
        check_eq("t2_state_halt", state_o, ST_HALT);
        check_eq("t2_halt", halt_o, 1);

        // Hold rule with repeated strobes and a competing lower monitor.
        do_clr();
        rpt_ready = 1'b0;
        t0 = tsm;
        viol_i = vbit(1, 0);
        tick();
        viol_i = '0;
        check_rpt("t3_first", 1, 0, t0);
        for (int k = 0; k < 5; k++) begin
            viol_i = (k == 1 || k == 3) ? vbit(1, 0) : ((k == 2) ? vbit(0, 1) : 32'd0);
            tick();
            check_rpt($sformatf("t3_hold%0d", k), 1, 0, t0);
        end
        viol_i = '0;
        check_eq("t3_drop_cnt", drop_cnt, 2);
        rpt_ready = 1'b1;
        tick();
        check_eq("t3_rpt_cnt", rpt_cnt, 1);
        check_eq("t3_state_drain", state_o, ST_DRAIN);
        check_rpt("t3_next", 0, 1, t0 + 3);
        tick();
        check_eq("t3_rpt_cnt2", rpt_cnt, 2);
        tick();
        check_eq("t3_halt", halt_o, 1);
        viol_i = vbit(1, 0);
        tick();
        viol_i = '0;
        check_eq("t3_halt_drop", drop_cnt, 2);
        check_eq("t3_halt_valid", rpt_valid, 0);

        // Fatal chk0 with two others pending; DRAIN ignores strobes.
        do_clr();
        rpt_ready = 1'b0;
        t0 = tsm;
        viol_i = vbit(0, 0) | vbit(1, 1) | vbit(3, 2);
        tick();
        viol_i = '0;
        check_rpt("t4a", 0, 0, t0);
        rpt_ready = 1'b1;
        tick();
        check_eq("t4_state_drain", state_o, ST_DRAIN);
        check_rpt("t4b", 1, 1, t0);
        viol_i = vbit(1, 1) | vbit(0, 5);
        tick();
        viol_i = '0;
        check_rpt("t4c", 3, 2, t0);
        tick();
        check_eq("t4_rpt_cnt", rpt_cnt, 3);
        check_eq("t4_valid_empty", rpt_valid, 0);
        tick();
        check_eq("t4_halt", halt_o, 1);
        check_eq("t4_drop_cnt", drop_cnt, 0);
        check_eq("t4_first_mon", first_mon, 0);
        check_eq("t4_first_chk", first_chk, 0);

        // DRAIN timeout with logger stalled.
        do_clr();
        rpt_ready = 1'b0;
        viol_i = vbit(0, 0) | vbit(0, 1);
        tick();
        viol_i = '0;
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        check_eq("t5_state_drain", state_o, ST_DRAIN);
        repeat (63) tick();
        check_eq("t5_state_63", state_o, ST_DRAIN);
        check_eq("t5_halt_63", halt_o, 0);
        tick();
        check_eq("t5_halt_64", halt_o, 1);
        check_eq("t5_valid_halt", rpt_valid, 0);

        // Asynchronous reset in DRAIN.
        do_clr();
        rpt_ready = 1'b1;
        viol_i = vbit(0, 0) | vbit(0, 1);
        tick();
        viol_i = '0;
        tick();
        rpt_ready = 1'b0;
        tick();
        check_eq("t6_state_drain", state_o, ST_DRAIN);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_state", state_o, ST_RUN);
        check_eq("t6_rst_halt", halt_o, 0);
        check_eq("t6_rst_valid", rpt_valid, 0);
        check_eq("t6_rst_rpt_cnt", rpt_cnt, 0);
        check_eq("t6_rst_first", first_vld, 0);
        @(negedge clock);
        reset_n = 1'b1;
        rpt_ready = 1'b1;
        viol_i = vbit(2, 0);
        tick();
        viol_i = '0;
        tick();
        tick();
        check_eq("t6_halt", halt_o, 1);
        check_eq("t6_rpt_cnt", rpt_cnt, 1);
        do_clr();
        check_eq("t6_clr_state", state_o, ST_RUN);
        check_eq("t6_clr_halt", halt_o, 0);
        check_eq("t6_clr_rpt_cnt", rpt_cnt, 0);
        check_eq("t6_clr_first", first_vld, 0);

        // Drop counter saturation: 32 drops per cycle once all bits are pending.
        rpt_ready = 1'b0;
        viol_i = '1;
        tick();
        check_eq("t7_drop_start", drop_cnt, 0);
        repeat (2050) tick();
        viol_i = '0;
        check_eq("t7_drop_sat", drop_cnt, 16'hffff);
        tick();
        check_eq("t7_drop_hold", drop_cnt, 16'hffff);
        check_eq("t7_state", state_o, ST_RUN);
        check_eq("t7_mon", rpt_mon, 0);
        check_eq("t7_chk", rpt_chk, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tl_monitor_event_scheduler.md
Name: tl_monitor_event_scheduler

Overview:
- Collects per-check violation strobes from NUM_MON bus-protocol monitor instances and holds them as sticky pending bits.
- Round-robin arbitrates among the monitors and emits one timestamped violation report per handshake to a single logger port.
- Captures the first error and sequences an orderly fatal halt (drain, then halt) instead of each monitor stopping simulation independently.
- Sits beside the monitor instances in the testbench/debug hierarchy.

Parameters:
- NUM_MON, 4, number of monitor instances served (>=2).
- NUM_CHK, 8, violation checks per monitor (>=1).
- TS_W, 32, timestamp counter width.
- CNT_W, 16, width of the report and drop counters.
- FATAL_MASK, {NUM_CHK{1'b1}}, per-check bit; 1 means a report of that check triggers the halt sequence.
- DRAIN_MAX, 64, maximum cycles spent in DRAIN before a forced halt.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable for viol_i.
- viol_i  in  NUM_MON*NUM_CHK  violation strobes; bit m*NUM_CHK+c is check c of monitor m.
- clr_i  in  1  synchronous clear of pending bits, counters, first-error capture and halt.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  logger accepts report.
- rpt_mon  out  clog2(NUM_MON)  reporting monitor index.
- rpt_chk  out  clog2(NUM_CHK)  check index.
- rpt_ts  out  TS_W  timestamp at which the bit became pending.
- first_vld  out  1  first-error capture is valid.
- first_mon  out  clog2(NUM_MON)  captured monitor index.
- first_chk  out  clog2(NUM_CHK)  captured check index.
- first_ts  out  TS_W  captured timestamp.
- rpt_cnt  out  CNT_W  accepted reports, saturating.
- drop_cnt  out  CNT_W  strobes lost because the bit was already pending, saturating.
- halt_o  out  1  halt request.
- state_o  out  2  FSM state (RUN=0, DRAIN=1, HALT=2).

Behaviour:
- Reset (async assert, sync release):
  - all pending bits, counters, timestamp and first_* are 0.
  - rpt_valid=0, halt_o=0, state=RUN.
- Timestamp: free-running TS_W counter, wraps to 0.
- Sampling: in RUN with enable=1, viol_i bit set at edge t makes the pending bit 1 at t+1, and ts_store[m][c] records ts(t).
- Drop counting: strobe on a bit already pending, not being cleared that edge, increments drop_cnt; its timestamp is unchanged.
- Same-edge set and clear of one bit: set wins; the bit stays pending with the new timestamp and is not counted as a drop.
- Arbitration:
  - monitor: round-robin starting from rr_ptr; any pending bit qualifies.
  - check within the chosen monitor: lowest pending index.
  - rpt_valid is combinational from the pending state, so first report latency is 1 cycle after the strobe.
- Hold rule: while rpt_valid=1 and rpt_ready=0, the grant is locked; rpt_mon, rpt_chk and rpt_ts are stable and new strobes do not change them.
- Handshake (rpt_valid & rpt_ready):
  - clears the granted pending bit and increments rpt_cnt.
  - rr_ptr becomes granted monitor+1, wrapping to 0 at NUM_MON.
- First error: first_* load on the first sampled strobe after reset or clr_i. If several bits rise at once, the lowest flat index wins. first_vld then stays 1.
- FSM:
  - RUN -> DRAIN on a handshake whose rpt_chk has FATAL_MASK=1.
  - DRAIN: new strobes are ignored (not counted, not set); reporting continues; drain counter runs from 0.
  - DRAIN -> HALT when no bits are pending, or when the drain counter reaches DRAIN_MAX-1.
  - HALT: halt_o=1, rpt_valid=0, remaining pending bits are frozen.
  - clr_i from any state -> RUN next cycle and clears everything except the timestamp; clr_i has priority over all other events.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package tl_monitor_pkg: state enum, index-width functions, report struct {mon, chk, ts}.
- One sub-module rr_arbiter (NUM_MON requests, grant index, lock input, pointer update on accept).
- Pending/timestamp storage, FSM and counters stay in the top level.

Test Plan:
- Single strobe viol_i[1*8+3] at ts=10, rpt_ready=1 -> at the next cycle rpt_valid=1, rpt_mon=1, rpt_chk=3, rpt_ts=10; rpt_cnt=1; first_* = {1,3,10}.
- Mon0 chk2, mon2 chk5 and mon3 chk0 in one cycle, rr_ptr=0 -> reports in order (0,2), (2,5), (3,0); rr_ptr ends at 0.
- rpt_ready=0 for 5 cycles while mon1 chk0 strobes twice more -> report fields stay stable, drop_cnt=2, a single report follows.
- FATAL_MASK=8'h01, chk0 reported with two other bits pending -> DRAIN, two more reports, then HALT with halt_o=1; later strobes give drop_cnt unchanged.
- DRAIN with rpt_ready held 0, DRAIN_MAX=64 -> halt_o=1 exactly 64 cycles after entering DRAIN.
- reset_n pulsed low mid-DRAIN -> all outputs 0 and state=RUN, asynchronously; clr_i in HALT -> RUN next cycle with counters 0.
